spi_rx_fifo: RTL and testbench
==============================

// Module: spi_rx_fifo
// PURPOSE
//  Receive buffer directly downstream of spi_rx: accepts words on the rx_rdata/rx_vld/rx_rdy handshake.
//  Stores them in a DEPTH-entry synchronous FIFO and presents them to the register/host side.
//  Uses a show-ahead valid/ready read port, a level counter and a threshold interrupt.
//  Overflow handling is selectable: backpressure spi_rx, or drop the word and flag it.
// PARAMETERS
//  DLY           1    simulation delay on all register assignments (#DLY)
//  SPI_RX_WIDTH  5    data bits per SPI frame
//  DATA_VLD      $clog2(SPI_RX_WIDTH)   width of valid-length field in each word
//  WIDTH         SPI_RX_WIDTH+DATA_VLD  stored word width; word = {vld_len, data}
//  DEPTH         8    FIFO entries; power of two, >=2
//  AW            $clog2(DEPTH)  pointer width
//  STALL         1    1: wr_rdy=0 when full; 0: wr_rdy=1 always, words arriving while full are dropped
// PORTS
//  clk       in   1        system clock
//  rstn      in   1        asynchronous active-low reset
//  clr       in   1        synchronous flush: empties FIFO, clears ovf
//  wr_data   in   WIDTH    word from spi_rx rx_rdata
//  wr_vld    in   1        spi_rx rx_vld
//  wr_rdy    out  1        to spi_rx rx_rdy
//  rd_data   out  WIDTH    head-of-FIFO word (valid only while rd_vld=1)
//  rd_vld    out  1        FIFO not empty
//  rd_rdy    in   1        consumer accepts head word
//  level     out  AW+1     current number of stored words, 0..DEPTH
//  thresh    in   AW+1     interrupt threshold; 0 disables irq
//  irq       out  1        level >= thresh (registered)
//  ovf       out  1        sticky: a word was dropped (STALL=0 only)
//  ovf_clr   in   1        clears ovf
// BEHAVIOUR
//  Reset (rstn=0, async): wr_ptr=rd_ptr=0, level=0, rd_vld=0, irq=0, ovf=0.
//   wr_rdy=1 after reset. Memory contents are not reset; rd_data=mem[0] is don't-care while rd_vld=0.
//  Fires: wr_fire = wr_vld & wr_rdy & ~full; rd_fire = rd_vld & rd_rdy.
//  full = (level==DEPTH); empty = (level==0).
//  Write: on wr_fire, mem[wr_ptr]<=wr_data; wr_ptr<=wr_ptr+1, wrapping DEPTH-1 -> 0.
//  Read: show-ahead. rd_data=mem[rd_ptr] combinationally; rd_vld=~empty.
//   On rd_fire, rd_ptr<=rd_ptr+1 with the same wrap.
//  Latency: a word written in cycle N is visible on rd_vld/rd_data in cycle N+1.
//  level: +1 on wr_fire only, -1 on rd_fire only, unchanged when both or neither.
//  Simultaneous read and write when full:
//   - STALL=1: wr_rdy=0 (wr_rdy=~full, registered-state based, no combinational path from rd_rdy).
//     The write is not taken; the read proceeds.
//   - STALL=0: full-cycle write is treated as a drop even if a read fires the same cycle.
//     ovf<=1, memory and wr_ptr unchanged.
//  Simultaneous read and write when empty: the read cannot fire (rd_vld=0); the write proceeds, level->1.
//  ovf: set on a STALL=0 drop. Cleared by ovf_clr or clr. Set wins over ovf_clr in the same cycle.
//  irq: registered each cycle from next-state level: irq <= (thresh!=0) && (level_next >= thresh).
//   Level-sensitive; deasserts once reads drop level below thresh. thresh > DEPTH gives irq=0.
//  clr: next cycle wr_ptr=rd_ptr=level=0, ovf=0, irq=0. clr has priority over wr_fire/rd_fire that cycle.
//   Data presented that cycle is discarded, not stored.
//  Reset asserted mid-operation: all state returns to reset values immediately.
//   No partial word survives; spi_rx sees wr_rdy=1 on release.
//  No arithmetic beyond pointer increment mod DEPTH and level +/-1. level never exceeds DEPTH or goes below 0.
// TESTING
//  1 Write 3 words 0x21,0x3F,0x05 with rd_rdy=0 -> level=3, rd_data=0x21.
//    Then rd_rdy=1 -> 0x21,0x3F,0x05 in order, then rd_vld=0, level=0.
//  2 STALL=1, rd_rdy=0, wr_vld held 1 for 10 cycles -> exactly 8 words stored.
//    wr_rdy=0 from the cycle level=8; ovf stays 0.
//  3 STALL=0, full FIFO, 2 extra writes with one concurrent read -> ovf=1, level=7.
//    Stored data is the first 8 words minus the one read; ovf_clr -> ovf=0.
//  4 thresh=4: write 4 words -> irq=1 in the cycle after the 4th write.
//    One read -> irq=0 the cycle after; thresh=0 -> irq never asserts.
//  5 Wrap-around: 20 words streamed with wr_vld=rd_rdy=1 continuously.
//    Output sequence matches input exactly; level stays <=1.
//  6 clr with level=5 and a concurrent write -> level=0, rd_vld=0, ovf=0 next cycle.
//    rstn pulsed low mid-stream -> all outputs return to reset values.

Source files
------------

// File: rtl/spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo
//
// Receive buffer that sits directly behind spi_rx. Words arrive on a
// valid/ready handshake, are held in a DEPTH-entry FIFO and are presented to
// the host side through a show-ahead read port. The block also reports the
// fill level, raises a threshold interrupt, and handles overflow in one of two
// ways: it either backpressures spi_rx or drops the word and records the drop.
//
// Ports
//   clk      : system clock
//   rstn     : asynchronous active-low reset
//   clr      : synchronous flush (empties the FIFO, clears ovf and irq)
//   wr_data  : incoming word {vld_len, data} from spi_rx
//   wr_vld   : incoming word valid
//   wr_rdy   : FIFO can take a word (always 1 when STALL=0)
//   rd_data  : head-of-FIFO word, meaningful only while rd_vld=1
//   rd_vld   : FIFO not empty
//   rd_rdy   : consumer takes the head word
//   level    : number of stored words, 0..DEPTH
//   thresh   : interrupt threshold, 0 disables the interrupt
//   irq      : registered level >= thresh
//   ovf      : sticky drop flag (STALL=0 only)
//   ovf_clr  : clears ovf
// -----------------------------------------------------------------------------
module spi_rx_fifo #(
    parameter int SPI_RX_WIDTH = 5,
    parameter int DATA_VLD     = $clog2(SPI_RX_WIDTH),
    parameter int WIDTH        = SPI_RX_WIDTH + DATA_VLD,
    parameter int DEPTH        = 8,
    parameter int AW           = $clog2(DEPTH),
    parameter bit STALL        = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_vld,
    output logic             wr_rdy,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [AW:0]      level,
    input  logic [AW:0]      thresh,
    output logic             irq,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic [AW:0]   level_next;
    logic          irq_reg;
    logic          ovf_reg;

    logic full;
    logic empty;
    logic wr_fire;
    logic rd_fire;
    logic drop;

    assign full  = (level_reg == FULL_LEVEL);
    assign empty = (level_reg == '0);

    // wr_rdy depends only on registered state, so rd_rdy never reaches it
    // combinationally; a read in a full cycle does not open the write side.
    assign wr_rdy  = STALL ? ~full : 1'b1;
    assign wr_fire = wr_vld & wr_rdy & ~full;
    assign rd_fire = ~empty & rd_rdy;

    // Without backpressure, any word offered while full is lost, even if a
    // read frees a slot in the same cycle.
    assign drop = (STALL == 1'b0) & wr_vld & full;

    assign rd_vld  = ~empty;
    assign rd_data = mem[rd_ptr_reg];
    assign level   = level_reg;
    assign irq     = irq_reg;
    assign ovf     = ovf_reg;

    always_comb begin
        level_next = level_reg;
        if (clr) begin
            level_next = '0;
        end else begin
            case ({wr_fire, rd_fire})
                2'b10:   level_next = level_reg + 1'b1;
                2'b01:   level_next = level_reg - 1'b1;
                default: level_next = level_reg;
            endcase
        end
    end

    // Storage array is deliberately left out of reset; rd_data is only
    // qualified by rd_vld.
    always_ff @(posedge clk) begin
        if (wr_fire && !clr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            irq_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            level_reg <= level_next;
            irq_reg   <= (thresh != '0) && (level_next >= thresh);
            if (clr) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                ovf_reg    <= 1'b0;
            end else begin
                // DEPTH is a power of two, so the natural AW-bit rollover
                // gives the DEPTH-1 -> 0 wrap.
                if (wr_fire) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (rd_fire) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                if (drop) begin
                    ovf_reg <= 1'b1;
                end else if (ovf_clr) begin
                    ovf_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_fifo
//
// Drives one STALL=1 instance (index 0) and one STALL=0 instance (index 1)
// from the same inputs. A queue-based reference model per instance predicts
// level, head word, wr_rdy, irq and ovf.
// -----------------------------------------------------------------------------
module tb_spi_rx_fifo;

    localparam int W = 8;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         wr_vld = 1'b0;
    logic         rd_rdy = 1'b0;
    logic [3:0]   thresh = '0;
    logic         ovf_clr = 1'b0;

    logic         wrdy [2];
    logic [W-1:0] rdat [2];
    logic         rv   [2];
    logic [3:0]   lvl  [2];
    logic         irqo [2];
    logic         ovfo [2];

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [W-1:0] mq0 [$];
    logic [W-1:0] mq1 [$];
    bit           m_irq [2];
    bit           m_ovf [2];
    logic [W-1:0] sent [32];

    always #5 clk = ~clk;

    spi_rx_fifo #(.STALL(1'b1)) u_stall (
        .clk(clk), .rstn(rstn), .clr(clr), .wr_data(wr_data), .wr_vld(wr_vld),
        .wr_rdy(wrdy[0]), .rd_data(rdat[0]), .rd_vld(rv[0]), .rd_rdy(rd_rdy),
        .level(lvl[0]), .thresh(thresh), .irq(irqo[0]), .ovf(ovfo[0]),
        .ovf_clr(ovf_clr)
    );

    spi_rx_fifo #(.STALL(1'b0)) u_drop (
        .clk(clk), .rstn(rstn), .clr(clr), .wr_data(wr_data), .wr_vld(wr_vld),
        .wr_rdy(wrdy[1]), .rd_data(rdat[1]), .rd_vld(rv[1]), .rd_rdy(rd_rdy),
        .level(lvl[1]), .thresh(thresh), .irq(irqo[1]), .ovf(ovfo[1]),
        .ovf_clr(ovf_clr)
    );

    function automatic int msize(int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [W-1:0] mhead(int k);
        if (k == 0) return (mq0.size() > 0) ? mq0[0] : '0;
        return (mq1.size() > 0) ? mq1[0] : '0;
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int k = 0; k < 2; k++) begin
            m_irq[k] = 1'b0;
            m_ovf[k] = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int sz = msize(k);
            bit full = (sz == D);
            bit wf = wr_vld && !full;
            bit rf = (sz > 0) && rd_rdy;
            bit dr = (k == 1) && wr_vld && full;
            if (clr) begin
                if (k == 0) mq0.delete(); else mq1.delete();
                m_ovf[k] = 1'b0;
            end else begin
                if (rf) begin
                    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                end
                if (wf) begin
                    if (k == 0) mq0.push_back(wr_data); else mq1.push_back(wr_data);
                end
                if (dr) m_ovf[k] = 1'b1;
                else if (ovf_clr) m_ovf[k] = 1'b0;
            end
            sz = msize(k);
            m_irq[k] = (thresh != 0) && (sz >= int'(thresh));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic flush();
        clr = 1'b1; wr_vld = 1'b0; rd_rdy = 1'b0; ovf_clr = 1'b0;
        cycle();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (lvl[k] !== 4'd0 || rv[k] !== 1'b0 || irqo[k] !== 1'b0 ||
                ovfo[k] !== 1'b0 || wrdy[k] !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset inst%0d: level=%0d rd_vld=%b irq=%b ovf=%b wr_rdy=%b, required 0 0 0 0 1",
                         k, lvl[k], rv[k], irqo[k], ovfo[k], wrdy[k]);
            end
        end
        rstn = 1'b1;
        @(negedge clk);
        $display("[TB] test_reset done");
    endtask

    task automatic test_order();
        logic [W-1:0] w [3];
        w[0] = 8'h21; w[1] = 8'h3F; w[2] = 8'h05;
        flush();
        thresh = 0;
        wr_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = w[i];
            cycle();
            tests_run++;
            if (lvl[0] !== 4'(i + 1) || rv[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL order_fill: level=%0d rd_vld=%b, required %0d 1", lvl[0], rv[0], i + 1);
            end
        end
        wr_vld = 1'b0;
        tests_run++;
        if (lvl[0] !== 4'd3 || rdat[0] !== 8'h21) begin
            tests_failed++;
            $display("FAIL order_head: level=%0d rd_data=%h, required 3 21", lvl[0], rdat[0]);
        end
        rd_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (rv[k] !== 1'b1 || rdat[k] !== w[i] || rdat[k] !== mhead(k)) begin
                    tests_failed++;
                    $display("FAIL order_read inst%0d #%0d: rd_vld=%b rd_data=%h, required 1 %h",
                             k, i, rv[k], rdat[k], w[i]);
                end
            end
            cycle();
        end
        rd_rdy = 1'b0;
        tests_run++;
        if (rv[0] !== 1'b0 || lvl[0] !== 4'd0) begin
            tests_failed++;
            $display("FAIL order_empty: rd_vld=%b level=%0d, required 0 0", rv[0], lvl[0]);
        end
        $display("[TB] test_order done");
    endtask

    task automatic test_stall_full();
        flush();
        wr_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_data = 8'($urandom);
            sent[i] = wr_data;
            tests_run++;
            if (wrdy[0] !== (i < 8) || wrdy[1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_wr_rdy cyc%0d: stall=%b drop=%b, required %b 1", i, wrdy[0], wrdy[1], i < 8);
            end
            cycle();
            tests_run++;
            if (lvl[0] !== 4'((i < 8) ? i + 1 : 8)) begin
                tests_failed++;
                $display("FAIL stall_level cyc%0d: level=%0d, required %0d", i, lvl[0], (i < 8) ? i + 1 : 8);
            end
        end
        wr_vld = 1'b0;
        tests_run++;
        if (ovfo[0] !== 1'b0 || ovfo[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_ovf: stall=%b drop=%b, required 0 1", ovfo[0], ovfo[1]);
        end
        rd_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (rdat[0] !== sent[i]) begin
                tests_failed++;
                $display("FAIL stall_data #%0d: rd_data=%h, required %h", i, rdat[0], sent[i]);
            end
            cycle();
        end
        rd_rdy = 1'b0;
        $display("[TB] test_stall_full done");
    endtask

    task automatic test_drop();
        flush();
        wr_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'($urandom);
            sent[i] = wr_data;
            cycle();
        end
        // extra write while full, with ovf_clr: the set must win
        wr_data = 8'($urandom);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        tests_run++;
        if (ovfo[1] !== 1'b1 || lvl[1] !== 4'd8) begin
            tests_failed++;
            $display("FAIL drop_first: ovf=%b level=%0d, required 1 8", ovfo[1], lvl[1]);
        end
        // extra write while full, concurrent with a read
        wr_data = 8'($urandom);
        rd_rdy = 1'b1;
        cycle();
        wr_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (lvl[k] !== 4'd7 || ovfo[k] !== m_ovf[k]) begin
                tests_failed++;
                $display("FAIL drop_second inst%0d: level=%0d ovf=%b, required 7 %b", k, lvl[k], ovfo[k], m_ovf[k]);
            end
        end
        for (int i = 1; i < 8; i++) begin
            tests_run++;
            if (rdat[1] !== sent[i] || rdat[0] !== sent[i]) begin
                tests_failed++;
                $display("FAIL drop_data #%0d: drop=%h stall=%h, required %h", i, rdat[1], rdat[0], sent[i]);
            end
            cycle();
        end
        rd_rdy = 1'b0;
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        tests_run++;
        if (ovfo[1] !== 1'b0 || rv[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_ovf_clr: ovf=%b rd_vld=%b, required 0 0", ovfo[1], rv[1]);
        end
        $display("[TB] test_drop done");
    endtask

    task automatic test_irq();
        flush();
        thresh = 4'd4;
        wr_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'($urandom);
            cycle();
            tests_run++;
            if (irqo[0] !== (i == 3) || irqo[0] !== m_irq[0]) begin
                tests_failed++;
                $display("FAIL irq_rise cyc%0d: irq=%b, required %b", i, irqo[0], i == 3);
            end
        end
        wr_vld = 1'b0;
        rd_rdy = 1'b1;
        cycle();
        rd_rdy = 1'b0;
        tests_run++;
        if (irqo[0] !== 1'b0 || lvl[0] !== 4'd3) begin
            tests_failed++;
            $display("FAIL irq_fall: irq=%b level=%0d, required 0 3", irqo[0], lvl[0]);
        end
        thresh = 4'd0;
        flush();
        wr_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'($urandom);
            cycle();
            tests_run++;
            if (irqo[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL irq_disabled cyc%0d: irq=%b, required 0", i, irqo[0]);
            end
        end
        wr_vld = 1'b0;
        thresh = 4'd8;
        cycle();
        tests_run++;
        if (irqo[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_at_depth: irq=%b, required 1", irqo[0]);
        end
        thresh = 4'd9;
        cycle();
        tests_run++;
        if (irqo[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_above_depth: irq=%b, required 0", irqo[0]);
        end
        thresh = 4'd0;
        $display("[TB] test_irq done");
    endtask

    task automatic test_wrap();
        int nout = 0;
        flush();
        wr_vld = 1'b1;
        rd_rdy = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i == 20) wr_vld = 1'b0;
            else begin
                wr_data = 8'($urandom);
                sent[i] = wr_data;
            end
            if (rv[0] === 1'b1) begin
                for (int k = 0; k < 2; k++) begin
                    tests_run++;
                    if (rdat[k] !== sent[nout]) begin
                        tests_failed++;
                        $display("FAIL wrap_data inst%0d #%0d: rd_data=%h, required %h", k, nout, rdat[k], sent[nout]);
                    end
                end
                nout++;
            end
            cycle();
            tests_run++;
            if (lvl[0] > 4'd1 || lvl[1] > 4'd1) begin
                tests_failed++;
                $display("FAIL wrap_level cyc%0d: levels=%0d %0d, required <=1", i, lvl[0], lvl[1]);
            end
        end
        rd_rdy = 1'b0;
        tests_run++;
        if (nout != 20 || rv[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_count: words out=%0d rd_vld=%b, required 20 0", nout, rv[0]);
        end
        $display("[TB] test_wrap done");
    endtask

    task automatic test_random();
        flush();
        for (int c = 0; c < 300; c++) begin
            int wbias = (c < 150) ? 75 : 35;
            wr_vld  = ($urandom_range(0, 99) < wbias);
            rd_rdy  = ($urandom_range(0, 99) < 50);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 9) == 0);
            clr     = ($urandom_range(0, 59) == 0);
            if (c % 50 == 0) thresh = 4'($urandom_range(0, 9));
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (wrdy[k] !== ((k == 1) || msize(k) < D)) begin
                    tests_failed++;
                    $display("FAIL rand_wr_rdy inst%0d cyc%0d: %b", k, c, wrdy[k]);
                end
            end
            cycle();
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (lvl[k] !== 4'(msize(k)) || rv[k] !== (msize(k) > 0) ||
                    (msize(k) > 0 && rdat[k] !== mhead(k)) ||
                    irqo[k] !== m_irq[k] || ovfo[k] !== m_ovf[k]) begin
                    tests_failed++;
                    $display("FAIL rand_state inst%0d cyc%0d: level=%0d/%0d rd_vld=%b data=%h/%h irq=%b/%b ovf=%b/%b",
                             k, c, lvl[k], msize(k), rv[k], rdat[k], mhead(k),
                             irqo[k], m_irq[k], ovfo[k], m_ovf[k]);
                end
            end
        end
        clr = 1'b0; wr_vld = 1'b0; rd_rdy = 1'b0; ovf_clr = 1'b0; thresh = 0;
        $display("[TB] test_random done");
    endtask

    task automatic test_clr_and_reset();
        flush();
        wr_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'($urandom);
            cycle();
        end
        clr = 1'b1;
        wr_data = 8'($urandom);
        cycle();
        clr = 1'b0;
        wr_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (lvl[k] !== 4'd0 || rv[k] !== 1'b0 || ovfo[k] !== 1'b0) begin
                tests_failed++;
                $display("FAIL clr inst%0d: level=%0d rd_vld=%b ovf=%b, required 0 0 0", k, lvl[k], rv[k], ovfo[k]);
            end
        end
        // build up state (full, ovf on drop instance, irq) then reset mid-cycle
        thresh = 4'd3;
        wr_vld = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_data = 8'($urandom);
            cycle();
        end
        tests_run++;
        if (ovfo[1] !== 1'b1 || irqo[0] !== 1'b1 || lvl[0] !== 4'd8) begin
            tests_failed++;
            $display("FAIL pre_reset: ovf=%b irq=%b level=%0d, required 1 1 8", ovfo[1], irqo[0], lvl[0]);
        end
        #2 rstn = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (lvl[k] !== 4'd0 || rv[k] !== 1'b0 || irqo[k] !== 1'b0 ||
                ovfo[k] !== 1'b0 || wrdy[k] !== 1'b1) begin
                tests_failed++;
                $display("FAIL async_reset inst%0d: level=%0d rd_vld=%b irq=%b ovf=%b wr_rdy=%b, required 0 0 0 0 1",
                         k, lvl[k], rv[k], irqo[k], ovfo[k], wrdy[k]);
            end
        end
        wr_vld = 1'b0;
        thresh = 4'd0;
        @(negedge clk);
        rstn = 1'b1;
        wr_vld = 1'b1;
        wr_data = 8'h5A;
        tests_run++;
        if (wrdy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_wr_rdy: %b, required 1", wrdy[0]);
        end
        cycle();
        wr_vld = 1'b0;
        tests_run++;
        if (lvl[0] !== 4'd1 || rdat[0] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL post_reset_write: level=%0d rd_data=%h, required 1 5a", lvl[0], rdat[0]);
        end
        $display("[TB] test_clr_and_reset done");
    endtask

    initial begin
        test_reset();
        test_order();
        test_stall_full();
        test_drop();
        test_irq();
        test_wrap();
        test_random();
        test_clr_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
